// File: rtl/ldst_mem_arbiter_if.sv
// Bus bundle between the two exec-stage load/store lanes, the arbiter and
// the single-ported data memory. The arbiter sits on the slave side.
interface ldst_mem_arbiter_if #(
  parameter int ADDR  = 16,
  parameter int W_OPR = 32
);

  // lane 0 request
  logic             req0_v_i;
  logic             req0_we_i;
  logic [ADDR-1:0]  req0_addr_i;
  logic [W_OPR-1:0] req0_data_i;
  logic             req0_rdy_o;

  // lane 1 request
  logic             req1_v_i;
  logic             req1_we_i;
  logic [ADDR-1:0]  req1_addr_i;
  logic [W_OPR-1:0] req1_data_i;
  logic             req1_rdy_o;

  // memory port
  logic             mem_busy_i;
  logic             mem_re_o;
  logic             mem_we_o;
  logic [ADDR-1:0]  mem_addr_o;
  logic [W_OPR-1:0] mem_wdata_o;
  logic [W_OPR-1:0] mem_rdata_i;

  // load responses
  logic             rsp0_v_o;
  logic             rsp1_v_o;
  logic [W_OPR-1:0] rsp_data_o;

  modport slave (
    input  req0_v_i, req0_we_i, req0_addr_i, req0_data_i,
    input  req1_v_i, req1_we_i, req1_addr_i, req1_data_i,
    input  mem_busy_i, mem_rdata_i,
    output req0_rdy_o, req1_rdy_o,
    output mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output rsp0_v_o, rsp1_v_o, rsp_data_o
  );

  modport master (
    output req0_v_i, req0_we_i, req0_addr_i, req0_data_i,
    output req1_v_i, req1_we_i, req1_addr_i, req1_data_i,
    output mem_busy_i, mem_rdata_i,
    input  req0_rdy_o, req1_rdy_o,
    input  mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  rsp0_v_o, rsp1_v_o, rsp_data_o
  );

endinterface

// File: rtl/ldst_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two
// load/store lanes. Grants are combinational, the memory port is registered,
// and loads are tracked by a fixed-latency {valid, lane} shift register so
// the read data can be steered back to the lane that issued it.
module ldst_mem_arbiter #(
  parameter int ADDR    = 16,
  parameter int W_OPR   = 32,
  parameter int MEM_LAT = 2
) (
  input logic              clk,
  input logic              rst_n,
  ldst_mem_arbiter_if.slave bus
);

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  lane_e              ptr_q;
  lane_e              issue_lane_q;
  lane_e              sel_lane;
  logic               gnt_v;
  logic               sel_we;
  logic [ADDR-1:0]    sel_addr;
  logic [W_OPR-1:0]   sel_data;
  logic [MEM_LAT-1:0] pipe_v_q;
  logic [MEM_LAT-1:0] pipe_lane_q;

  // Pick the lane to serve this cycle: single requester wins outright, a tie goes to the lane not served last.
  always_comb begin
    gnt_v    = 1'b0;
    sel_lane = LANE0;
    if (!bus.mem_busy_i) begin
      if (bus.req0_v_i && bus.req1_v_i) begin
        gnt_v    = 1'b1;
        sel_lane = (ptr_q == LANE1) ? LANE0 : LANE1;
      end else if (bus.req0_v_i) begin
        gnt_v    = 1'b1;
        sel_lane = LANE0;
      end else if (bus.req1_v_i) begin
        gnt_v    = 1'b1;
        sel_lane = LANE1;
      end
    end
  end

  assign bus.req0_rdy_o = gnt_v && (sel_lane == LANE0);
  assign bus.req1_rdy_o = gnt_v && (sel_lane == LANE1);

  // Route the selected lane's access fields toward the memory port registers.
  always_comb begin
    sel_we   = bus.req0_we_i;
    sel_addr = bus.req0_addr_i;
    sel_data = bus.req0_data_i;
    if (sel_lane == LANE1) begin
      sel_we   = bus.req1_we_i;
      sel_addr = bus.req1_addr_i;
      sel_data = bus.req1_data_i;
    end
  end

  // Register the memory access, advance the load-return pipeline and deliver responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q           <= LANE1;
      issue_lane_q    <= LANE0;
      bus.mem_re_o    <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      pipe_v_q        <= '0;
      pipe_lane_q     <= '0;
      bus.rsp0_v_o    <= 1'b0;
      bus.rsp1_v_o    <= 1'b0;
      bus.rsp_data_o  <= '0;
    end else begin
      if (gnt_v) begin
        ptr_q           <= sel_lane;
        issue_lane_q    <= sel_lane;
        bus.mem_re_o    <= ~sel_we;
        bus.mem_we_o    <= sel_we;
        bus.mem_addr_o  <= sel_addr;
        bus.mem_wdata_o <= sel_data;
      end else begin
        bus.mem_re_o <= 1'b0;
        bus.mem_we_o <= 1'b0;
      end

      pipe_v_q[0]    <= bus.mem_re_o;
      pipe_lane_q[0] <= issue_lane_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v_q[i]    <= pipe_v_q[i-1];
        pipe_lane_q[i] <= pipe_lane_q[i-1];
      end

      bus.rsp0_v_o <= pipe_v_q[MEM_LAT-1] && (pipe_lane_q[MEM_LAT-1] == LANE0);
      bus.rsp1_v_o <= pipe_v_q[MEM_LAT-1] && (pipe_lane_q[MEM_LAT-1] == LANE1);
      if (pipe_v_q[MEM_LAT-1]) begin
        bus.rsp_data_o <= bus.mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ldst_mem_arbiter.sv
// Testbench for ldst_mem_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model
// (round-robin rule, expected memory image, queue of due load responses).
module tb_ldst_mem_arbiter;

  localparam int ADDR    = 16;
  localparam int W_OPR   = 32;
  localparam int MEM_LAT = 2;

  typedef struct {
    int               due;
    int               lane;
    logic [W_OPR-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ldst_mem_arbiter_if #(.ADDR(ADDR), .W_OPR(W_OPR)) bus ();

  ldst_mem_arbiter #(.ADDR(ADDR), .W_OPR(W_OPR), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // memory device with MEM_LAT read latency
  logic [W_OPR-1:0] phys_mem [logic [ADDR-1:0]];
  logic [W_OPR-1:0] rd_pipe [MEM_LAT];

  // reference state
  logic [W_OPR-1:0] ref_mem [logic [ADDR-1:0]];
  rsp_t             rsp_q[$];
  int               ptr_m;
  bit               exp_iss_v;
  bit               exp_iss_we;
  logic [ADDR-1:0]  exp_addr;
  logic [W_OPR-1:0] exp_wdata;
  logic [W_OPR-1:0] exp_rsp_data;
  int               cyc;

  // requester state
  bit               pend_v [2];
  bit               pend_we [2];
  logic [ADDR-1:0]  pend_addr [2];
  logic [W_OPR-1:0] pend_data [2];
  bit               busy_drv;

  // observed DUT behaviour
  int               obs_gnt_lane[$];
  int               obs_gnt_cyc[$];
  int               obs_rsp_lane[$];
  int               obs_rsp_cyc[$];
  logic [W_OPR-1:0] obs_rsp_data[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [W_OPR-1:0] init_word(input logic [ADDR-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  function automatic logic [W_OPR-1:0] phys_read(input logic [ADDR-1:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [W_OPR-1:0] ref_read(input logic [ADDR-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [W_OPR-1:0] d_at(input logic [W_OPR-1:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Memory device: writes land on the edge, reads come back MEM_LAT cycles later.
  always @(posedge clk) begin
    if (bus.mem_we_o) phys_mem[bus.mem_addr_o] = bus.mem_wdata_o;
    rd_pipe[0] <= bus.mem_re_o ? phys_read(bus.mem_addr_o) : '0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_rdata_i = rd_pipe[MEM_LAT-1];

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.req0_v_i    = pend_v[0];
    bus.req0_we_i   = pend_we[0];
    bus.req0_addr_i = pend_addr[0];
    bus.req0_data_i = pend_data[0];
    bus.req1_v_i    = pend_v[1];
    bus.req1_we_i   = pend_we[1];
    bus.req1_addr_i = pend_addr[1];
    bus.req1_data_i = pend_data[1];
    bus.mem_busy_i  = busy_drv;
  endtask

  task automatic post_req(input int lane, input bit we, input logic [ADDR-1:0] a,
                          input logic [W_OPR-1:0] d);
    pend_v[lane]    = 1'b1;
    pend_we[lane]   = we;
    pend_addr[lane] = a;
    pend_data[lane] = d;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic applyStimulus();
    rsp_t r;
    bit   exp_v0;
    bit   exp_v1;
    int   g;
    checkOutput("mem_re", bus.mem_re_o, exp_iss_v & ~exp_iss_we);
    checkOutput("mem_we", bus.mem_we_o, exp_iss_v & exp_iss_we);
    checkOutput("mem_addr", bus.mem_addr_o, exp_addr);
    checkOutput("mem_wdata", bus.mem_wdata_o, exp_wdata);
    exp_v0 = 1'b0;
    exp_v1 = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (r.lane == 0) exp_v0 = 1'b1;
      else exp_v1 = 1'b1;
      exp_rsp_data = r.data;
    end
    checkOutput("rsp0_v", bus.rsp0_v_o, exp_v0);
    checkOutput("rsp1_v", bus.rsp1_v_o, exp_v1);
    checkOutput("rsp_data", bus.rsp_data_o, exp_rsp_data);
    if (bus.rsp0_v_o || bus.rsp1_v_o) begin
      obs_rsp_lane.push_back(bus.rsp1_v_o ? 1 : 0);
      obs_rsp_cyc.push_back(cyc);
      obs_rsp_data.push_back(bus.rsp_data_o);
    end

    drive_inputs();
    #1;
    if (busy_drv) g = -1;
    else if (pend_v[0] && pend_v[1]) g = 1 - ptr_m;
    else if (pend_v[0]) g = 0;
    else if (pend_v[1]) g = 1;
    else g = -1;
    checkOutput("req0_rdy", bus.req0_rdy_o, g == 0);
    checkOutput("req1_rdy", bus.req1_rdy_o, g == 1);
    if (bus.req0_rdy_o) begin obs_gnt_lane.push_back(0); obs_gnt_cyc.push_back(cyc); end
    if (bus.req1_rdy_o) begin obs_gnt_lane.push_back(1); obs_gnt_cyc.push_back(cyc); end

    exp_iss_v = 1'b0;
    if (g >= 0) begin
      ptr_m      = g;
      exp_iss_v  = 1'b1;
      exp_iss_we = pend_we[g];
      exp_addr   = pend_addr[g];
      exp_wdata  = pend_data[g];
      if (pend_we[g]) ref_mem[pend_addr[g]] = pend_data[g];
      else rsp_q.push_back('{cyc + 2 + MEM_LAT, g, ref_read(pend_addr[g])});
      pend_v[g] = 1'b0;
    end

    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    busy_drv  = 1'b0;
    drive_inputs();
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
    rst_n        = 1'b1;
    ptr_m        = 1;
    exp_iss_v    = 1'b0;
    exp_iss_we   = 1'b0;
    exp_addr     = '0;
    exp_wdata    = '0;
    exp_rsp_data = '0;
    rsp_q.delete();
  endtask

  task automatic wait_grant(input int lane, input int budget);
    int n = 0;
    while (pend_v[lane] && n < budget) begin
      applyStimulus();
      n++;
    end
    if (pend_v[lane]) checkOutput("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic clear_logs();
    obs_gnt_lane.delete();
    obs_gnt_cyc.delete();
    obs_rsp_lane.delete();
    obs_rsp_cyc.delete();
    obs_rsp_data.delete();
  endtask

  initial begin
    cyc       = 0;
    pend_we   = '{1'b0, 1'b0};
    pend_addr = '{16'h0, 16'h0};
    pend_data = '{32'h0, 32'h0};
    phys_mem[16'h0010] = 32'hDEADBEEF;
    ref_mem[16'h0010]  = 32'hDEADBEEF;

    // reset then idle
    do_reset(2);
    drain(3);

    // single load from lane 0
    clear_logs();
    post_req(0, 1'b0, 16'h0010, 32'h0);
    wait_grant(0, 8);
    drain(3 + MEM_LAT);
    checkOutput("single_gnt_lane", q_at(obs_gnt_lane, 0), 0);
    checkOutput("single_rsp_count", obs_rsp_lane.size(), 1);
    checkOutput("single_rsp_lane", q_at(obs_rsp_lane, 0), 0);
    checkOutput("single_latency", q_at(obs_rsp_cyc, 0) - q_at(obs_gnt_cyc, 0), 2 + MEM_LAT);
    checkOutput("single_rsp_data", d_at(obs_rsp_data, 0), 32'hDEADBEEF);

    // contention: both lanes load continuously
    do_reset(2);
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      if (!pend_v[0]) post_req(0, 1'b0, 16'(16'h0100 + 8 * k), 32'h0);
      if (!pend_v[1]) post_req(1, 1'b0, 16'(16'h0104 + 8 * k), 32'h0);
      applyStimulus();
    end
    wait_grant(0, 4);
    wait_grant(1, 4);
    drain(4 + MEM_LAT);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("cont_gnt%0d", k), q_at(obs_gnt_lane, k), k % 2);
      checkOutput($sformatf("cont_rsp%0d", k), q_at(obs_rsp_lane, k), k % 2);
    end
    checkOutput("cont_rsp_spacing", q_at(obs_rsp_cyc, 3) - q_at(obs_rsp_cyc, 0), 3);

    // store from lane 1 then load of the same address from lane 0
    clear_logs();
    post_req(1, 1'b1, 16'h0020, 32'h12345678);
    wait_grant(1, 8);
    post_req(0, 1'b0, 16'h0020, 32'h0);
    wait_grant(0, 8);
    drain(4 + MEM_LAT);
    checkOutput("st_ld_rsp_count", obs_rsp_lane.size(), 1);
    checkOutput("st_ld_rsp_lane", q_at(obs_rsp_lane, 0), 0);
    checkOutput("st_ld_rsp_data", d_at(obs_rsp_data, 0), 32'h12345678);

    // busy back-pressure with a load already in flight
    clear_logs();
    post_req(0, 1'b0, 16'h0030, 32'h0);
    wait_grant(0, 8);
    busy_drv = 1'b1;
    post_req(1, 1'b0, 16'h0034, 32'h0);
    drain(3);
    busy_drv = 1'b0;
    wait_grant(1, 4);
    drain(4 + MEM_LAT);
    checkOutput("busy_gnt_gap", q_at(obs_gnt_cyc, 1) - q_at(obs_gnt_cyc, 0), 4);
    checkOutput("busy_gnt_lane", q_at(obs_gnt_lane, 1), 1);
    checkOutput("busy_inflight_lat", q_at(obs_rsp_cyc, 0) - q_at(obs_gnt_cyc, 0), 2 + MEM_LAT);

    // reset while a load is in flight
    clear_logs();
    post_req(0, 1'b0, 16'h0040, 32'h0);
    wait_grant(0, 8);
    applyStimulus();
    do_reset(1);
    drain(4 + MEM_LAT);
    checkOutput("rst_flight_no_rsp", obs_rsp_lane.size(), 0);
    post_req(0, 1'b0, 16'h0044, 32'h0);
    post_req(1, 1'b0, 16'h0048, 32'h0);
    applyStimulus();
    checkOutput("rst_tie_lane", q_at(obs_gnt_lane, 1), 0);
    wait_grant(1, 4);
    drain(4 + MEM_LAT);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      busy_drv = ($urandom_range(0, 99) < 20);
      for (int l = 0; l < 2; l++) begin
        if (!pend_v[l] && $urandom_range(0, 99) < 55)
          post_req(l, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 15) * 4), $urandom);
      end
      applyStimulus();
    end
    busy_drv = 1'b0;
    wait_grant(0, 4);
    wait_grant(1, 4);
    drain(4 + MEM_LAT);
    checkOutput("rand_rsp_drained", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldst_mem_arbiter.md
Name: ldst_mem_arbiter

Overview:
- Shares one single-ported data memory between two load/store requesters: lane 0 and lane 1 exec load/store units.
- Each lane presents an address, a write strobe and store data, as produced by the exec-stage load/store logic.
- The block grants at most one access per cycle with round-robin fairness and drives a registered memory port.
- It tracks in-flight loads through a fixed-latency return pipeline and steers read data back to the issuing lane.

Parameters:
ADDR, 16, memory address width in bits
W_OPR, 32, data width in bits
MEM_LAT, 2, memory read latency in cycles from mem_re_o sampled high to mem_rdata_i valid; legal range 1..4

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req0_v_i  input  1  lane 0 request valid
req0_we_i  input  1  lane 0 request is a store (1) or a load (0)
req0_addr_i  input  ADDR  lane 0 address
req0_data_i  input  W_OPR  lane 0 store data
req0_rdy_o  output  1  lane 0 granted this cycle
req1_v_i  input  1  lane 1 request valid
req1_we_i  input  1  lane 1 store (1) or load (0)
req1_addr_i  input  ADDR  lane 1 address
req1_data_i  input  W_OPR  lane 1 store data
req1_rdy_o  output  1  lane 1 granted this cycle
mem_busy_i  input  1  memory cannot accept an access this cycle
mem_re_o  output  1  memory read enable, registered
mem_we_o  output  1  memory write enable, registered
mem_addr_o  output  ADDR  memory address, registered
mem_wdata_o  output  W_OPR  memory write data, registered
mem_rdata_i  input  W_OPR  memory read data, valid MEM_LAT cycles after mem_re_o
rsp0_v_o  output  1  load data for lane 0 valid, registered
rsp1_v_o  output  1  load data for lane 1 valid, registered
rsp_data_o  output  W_OPR  load data, registered; shared by both lanes

Behaviour:
- Reset (rst_n low at a clock edge):
  - mem_re_o, mem_we_o, rsp0_v_o and rsp1_v_o go to 0; mem_addr_o, mem_wdata_o and rsp_data_o go to 0.
  - Priority pointer goes to 1, meaning lane 1 was last served, so lane 0 wins the first tie.
  - All in-flight load tags are cleared. Loads issued before reset never produce a response.
- Grant logic is combinational within the cycle:
  - If mem_busy_i=1, there is no grant.
  - If exactly one lane's v_i=1, that lane is granted.
  - If both lanes are valid, the lane not equal to the pointer is granted.
  - reqN_rdy_o = grant to lane N. At most one rdy is high per cycle.
- Pointer update: set to the granted lane on a grant; unchanged when there is no grant.
- Requester protocol:
  - v/we/addr/data must be held stable until rdy_o is sampled high.
  - A transfer occurs on a cycle where both v_i and rdy_o are high.
  - The requester may drop v_i only after the transfer.
- Issue: the cycle after a grant, the memory port outputs for that access are:
  - mem_addr_o = granted addr.
  - mem_we_o = granted we.
  - mem_re_o = ~granted we.
  - mem_wdata_o = granted data.
- With no grant, the next cycle has mem_re_o=0 and mem_we_o=0; mem_addr_o and mem_wdata_o hold their previous values.
- Return pipeline:
  - A shift register of MEM_LAT stages, each holding {valid, lane}, is loaded with {mem_re_o, lane} every cycle.
  - When the last stage is valid, on the next edge rsp_data_o captures mem_rdata_i and rsp<lane>_v_o=1 for exactly one cycle.
  - Total load latency is 2+MEM_LAT cycles from the grant edge to rspN_v_o high. For MEM_LAT=2, a grant in cycle t gives a response in cycle t+4.
- Stores generate no response.
- Loads return strictly in issue order. One load can be issued per cycle, so back-to-back responses are allowed.
- mem_busy_i only blocks new grants. Already-registered accesses and in-flight loads proceed unaffected.
- A new request arriving on the same cycle a response is delivered to that lane is legal and independent.
- rsp_data_o holds its last value when no response is valid.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> all outputs 0; no rdy with both v_i=0.
- Single load: lane 0 load at addr 0x0010, memory model returns 0xDEADBEEF -> req0_rdy_o=1 in cycle t; mem_re_o=1, mem_addr_o=0x0010 at t+1; rsp0_v_o=1, rsp_data_o=0xDEADBEEF at t+4; rsp1_v_o stays 0.
- Contention: both lanes request loads continuously for 4 cycles after reset -> grant order is lane0, lane1, lane0, lane1; responses arrive in the same order, one per cycle.
- Store then load, same address: lane 1 stores 0x12345678 to 0x0020, then lane 0 loads 0x0020 -> mem_we_o=1 with mem_wdata_o=0x12345678, no response for the store; the load returns 0x12345678 on rsp0.
- Busy back-pressure: mem_busy_i=1 for 3 cycles while lane 1 holds a request -> req1_rdy_o=0 for those 3 cycles, grant on the first non-busy cycle, and an already in-flight load still returns on time.
- Reset mid-flight: issue a load, assert rst_n=0 at grant+2 -> no rsp*_v_o ever asserts for that load; the pointer is back to 1, so a subsequent tie grants lane 0.
